stopwatch_display: RTL and testbench
====================================

# stopwatch_display

Downstream display stage for the stopwatch counter. It takes the eight BCD time digits (HH MM SS cc), snapshots them once per scan frame so digits never tear, and drives a time-multiplexed 8-digit common-anode seven-segment display. Optionally it can freeze the shown time for a lap split. It sits between the stopwatch counter outputs and the board display pins.

## Interface
- SCAN_DIV, 50_000, clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range ≥ 2
- clock  in  1  system clock, 50 MHz
- reset  in  1  one clock; reset is synchronous and active-high
- d8..d1  in  4 each  BCD digits from the counter; d1 = 0.01 s, d8 = tens of hours
- lap  in  1  single-cycle pulse from the upstream debouncer; toggles lap hold
- seg_n  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- dp_n  out  1  decimal point, active-low
- an_n  out  8  digit enables, active-low one-hot; an_n[i] selects digit d(i+1)
- lap_active  out  1  high while the display is frozen by lap hold

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. Digit index `idx` (3 bits) advances by 1 on the cycle `pre` == SCAN_DIV-1, wrapping 7→0.
- Frame register: 8×4 bits. It loads d8..d1 on the frame-boundary cycle (`pre` == SCAN_DIV-1 and `idx` == 7), unless hold applies. Otherwise it keeps its value.
- Ghost blanking: during the cycle `pre` == 0, no digit is enabled.
- Decode of the frame digit at `idx`:
  - Values 0–9 produce the standard glyphs.
  - Values 10–15 produce a dash (segment g only, seg_n = 7'b0111111).
- Decimal points are lit on idx 2, 4 and 6 (d3, d5, d7), giving the format HH.MM.SS.cc.
- Leading-zero blank: when frame d8 == 0, slot 7 shows nothing (seg_n = 7'h7F, dp_n = 1). an_n is still driven normally in that slot.
- Lap hold (macro-gated, see Configuration):
  - A lap pulse toggles `hold`. lap_active equals `hold`.
  - While `hold` = 1, no frame loads occur.
  - Simultaneous lap pulse and frame boundary: the post-toggle `hold` value decides whether that boundary loads. A pulse that sets hold blocks the load. A pulse that clears hold allows it.
  - After release without a coincident boundary, live time resumes at the next frame boundary.

## Timing
- All outputs are registered. They are a function of the `pre`, `idx` and frame values from the previous cycle, so there is one cycle of latency.
- Reset values: an_n = 8'hFF, seg_n = 7'h7F, dp_n = 1, lap_active = 0. Internal state resets to `pre` = 0, `idx` = 0, frame = all zero, hold = 0.
- First cycle after reset deasserts: outputs remain blank.
- Second cycle after reset deasserts: an_n = 8'hFE.
- Slot length: each digit is enabled for SCAN_DIV-1 cycles, then 1 blank cycle. A full frame is 8·SCAN_DIV cycles.
- Frame contents shown on the display change only at the first slot-0 enable after a load.
- Reset mid-hold or mid-slot: everything returns to the reset values on the next edge. hold clears and the frame zeroes.
- Input digits need no relation to the scan. They are sampled only at the boundary, and the counter is in the same clock domain.

## Configuration
- STOPWATCH_DISPLAY_LAP_EN
  - Defined: the lap input, `hold` register and lap_active are implemented as described.
  - Undefined: lap is ignored and lap_active is tied 0. The frame loads at every boundary and the hold register is not synthesized.

## Structure
- Shared package stopwatch_pkg holds:
  - the 7-segment glyph constants SEG_0..SEG_9 and SEG_DASH (active-low {g..a});
  - SEG_BLANK = 7'h7F;
  - DP_MASK = 8'b0101_0100 (idx 2, 4, 6).
- One sub-module: bcd_to_7seg, a combinational 4-bit→7-bit decoder that uses the package constants and includes dash for 10–15.
- Prescaler, index, frame register, hold flag and output registers live in the top module.

## Test plan
All scenarios use SCAN_DIV = 4 and lap enabled unless stated.
- Reset held for 3 cycles, then released → during reset and the first cycle after: an_n = FF, seg_n = 7F, dp_n = 1, lap_active = 0. Second cycle after release: an_n = FE, seg_n = 7'h40 (glyph 0).
- Inputs d8..d1 = 1,2,3,4,5,6,7,8, wait one frame → an_n steps FE, FD, …, 7F, each slot 3 cycles plus 1 blank. The d1 slot shows seg_n = 7'h00 (8). dp_n = 0 only in slots 2, 4, 6.
- Change d1 from 8 to 3 mid-frame → displayed d1 stays 8 until after the idx-7 boundary, then shows 7'h30 (3).
- Boundary digits:
  - d8 = 0 → slot 7 shows seg_n = 7F, dp_n = 1.
  - d8 = 4'hA → slot 7 shows seg_n = 7'h3F (dash).
- Lap:
  - Pulse lap → lap_active = 1. Inputs change over 3 frames; the display stays frozen.
  - Second pulse → lap_active = 0 and new values appear after the next boundary.
  - Pulse coinciding with a boundary while unheld → no load.
- Reset asserted while held → lap_active = 0 and the frame reads all zero; slot 7 blank, others show 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared constants for the stopwatch display path.
//                Seven-segment glyphs are active-low, bit order {g,f,e,d,c,b,a}.
//                DP_MASK marks the digit slots whose decimal point is lit,
//                giving the HH.MM.SS.cc layout.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    localparam int N_DIGITS = 8;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    //                                      gfedcba
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'h7F;

    // Bit i set: decimal point lit while slot i is enabled (d3, d5, d7).
    localparam logic [N_DIGITS-1:0] DP_MASK = 8'b0101_0100;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_7seg
//  Description : Combinational BCD to seven-segment decoder (active-low).
//                Codes 0-9 give the standard glyphs; the non-BCD codes 10-15
//                give a dash so corrupted upstream data is visible on the
//                display instead of masquerading as a valid digit.
//  Ports       : i_bcd   [3:0]  BCD digit
//                o_seg_n [6:0]  segments, active-low {g,f,e,d,c,b,a}
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg_n = SEG_0;
            4'd1:    o_seg_n = SEG_1;
            4'd2:    o_seg_n = SEG_2;
            4'd3:    o_seg_n = SEG_3;
            4'd4:    o_seg_n = SEG_4;
            4'd5:    o_seg_n = SEG_5;
            4'd6:    o_seg_n = SEG_6;
            4'd7:    o_seg_n = SEG_7;
            4'd8:    o_seg_n = SEG_8;
            4'd9:    o_seg_n = SEG_9;
            default: o_seg_n = SEG_DASH;
        endcase
    end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_display
//  Description : Time-multiplexed driver for an 8-digit common-anode
//                seven-segment display showing HH.MM.SS.cc. The eight input
//                digits are snapshotted into a frame register once per scan
//                frame so a digit never tears mid-scan. Optional lap hold
//                freezes the frame until released.
//  Parameters  : SCAN_DIV  clock cycles per digit slot (>= 2)
//  Ports       : clock       system clock
//                reset       synchronous, active-high
//                d8..d1      BCD digits (d1 = 0.01 s, d8 = tens of hours)
//                lap         single-cycle pulse, toggles lap hold
//                seg_n [6:0] segments, active-low {g,f,e,d,c,b,a}
//                dp_n        decimal point, active-low
//                an_n  [7:0] digit enables, active-low; an_n[i] -> d(i+1)
//                lap_active  high while the display is frozen
//  Macros      : STOPWATCH_DISPLAY_LAP_EN  implements lap hold when defined;
//                otherwise lap is ignored and lap_active is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d8,
    input  logic [3:0] d7,
    input  logic [3:0] d6,
    input  logic [3:0] d5,
    input  logic [3:0] d4,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic       lap,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [7:0] an_n,
    output logic       lap_active
);

    localparam int                 c_PRE_W    = $clog2(SCAN_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [2:0]         c_IDX_LAST = 3'd7;

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0]      r_pre;
    logic [2:0]              r_idx;
    logic [N_DIGITS-1:0][3:0] r_frame;

    logic w_slot_end;   // last cycle of the current digit slot
    logic w_boundary;   // last cycle of the whole frame
    logic w_load;       // frame register captures the live digits

    assign w_slot_end = (r_pre == c_PRE_LAST);
    assign w_boundary = w_slot_end && (r_idx == c_IDX_LAST);

    // ------------------------------------------------------------------
    // Lap hold
    // ------------------------------------------------------------------
`ifdef STOPWATCH_DISPLAY_LAP_EN
    logic r_hold;
    logic w_hold_next;

    // The post-toggle value gates a coincident boundary, so a pulse that
    // sets hold blocks that load and a pulse that clears hold allows it.
    assign w_hold_next = r_hold ^ lap;
    assign w_load      = w_boundary && !w_hold_next;
    assign lap_active  = r_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold <= 1'b0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`else
    logic w_unused_lap;

    assign w_unused_lap = lap;
    assign w_load       = w_boundary;
    assign lap_active   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Prescaler, digit index and frame snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            if (w_slot_end) begin
                r_pre <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            if (w_load) begin
                r_frame <= {d8, d7, d6, d5, d4, d3, d2, d1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit decode
    // ------------------------------------------------------------------
    logic [3:0] w_digit;
    logic [6:0] w_glyph;
    logic       w_lead_blank;

    assign w_digit      = r_frame[r_idx];
    assign w_lead_blank = (r_idx == c_IDX_LAST) && (r_frame[N_DIGITS-1] == 4'd0);

    bcd_to_7seg u_dec (
        .i_bcd   (w_digit),
        .o_seg_n (w_glyph)
    );

    // ------------------------------------------------------------------
    // Output composition
    // ------------------------------------------------------------------
    // The first cycle of every slot is fully blank (anodes, segments and
    // decimal point) so the previous digit cannot ghost into the next one
    // while the anode drivers switch.
    logic [7:0] w_an_n_next;
    logic [6:0] w_seg_n_next;
    logic       w_dp_n_next;

    always_comb begin
        w_an_n_next  = 8'hFF;
        w_seg_n_next = SEG_BLANK;
        w_dp_n_next  = 1'b1;
        if (r_pre != '0) begin
            w_an_n_next = ~(8'd1 << r_idx);
            w_dp_n_next = ~DP_MASK[r_idx];
            if (!w_lead_blank) begin
                w_seg_n_next = w_glyph;
            end
        end
    end

    logic [7:0] r_an_n;
    logic [6:0] r_seg_n;
    logic       r_dp_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_an_n  <= 8'hFF;
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
        end else begin
            r_an_n  <= w_an_n_next;
            r_seg_n <= w_seg_n_next;
            r_dp_n  <= w_dp_n_next;
        end
    end

    assign an_n  = r_an_n;
    assign seg_n = r_seg_n;
    assign dp_n  = r_dp_n;

endmodule : stopwatch_display
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_display
//  Description : Self-checking bench for stopwatch_display with SCAN_DIV = 4.
//                A cycle-count based reference model predicts every output on
//                every cycle; a few literal checks pin the model itself.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_display;

    localparam int D     = 4;
    localparam int FRAME = 8 * D;
`ifdef STOPWATCH_DISPLAY_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       lap;
    logic [3:0] dg [8];
    logic [6:0] seg_n;
    logic       dp_n;
    logic [7:0] an_n;
    logic       lap_active;

    always #5 clock = ~clock;

    stopwatch_display #(.SCAN_DIV(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .d8         (dg[7]),
        .d7         (dg[6]),
        .d6         (dg[5]),
        .d5         (dg[4]),
        .d4         (dg[3]),
        .d3         (dg[2]),
        .d2         (dg[1]),
        .d1         (dg[0]),
        .lap        (lap),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .lap_active (lap_active)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: position in the scan comes straight from the
    // number of clocks since reset; the shown frame is whatever was latched
    // at the last unheld frame end.
    // ------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [7:0] model_an(input int c);
        logic [7:0] a;
        a = 8'hFF;
        if (c % D != 0) a[(c / D) % 8] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] model_seg(input int c, input logic [7:0][3:0] f);
        int slot;
        slot = (c / D) % 8;
        if (c % D == 0) return 7'h7F;
        if (slot == 7 && f[7] == 4'd0) return 7'h7F;
        return glyph(f[slot]);
    endfunction

    function automatic logic model_dp(input int c);
        int slot;
        slot = (c / D) % 8;
        if (c % D == 0) return 1'b1;
        return !(slot == 2 || slot == 4 || slot == 6);
    endfunction

    int               m_cyc   = 0;
    logic [7:0][3:0]  m_frame = '0;
    bit               m_hold  = 1'b0;
    bit               m_valid = 1'b0;
    logic [7:0]       exp_an;
    logic [6:0]       exp_seg;
    logic             exp_dp;
    logic             exp_lap;

    always @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_cyc   <= 0;
            m_frame <= '0;
            m_hold  <= 1'b0;
            exp_an  <= 8'hFF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
            exp_lap <= 1'b0;
        end else begin
            exp_an  <= model_an(m_cyc);
            exp_seg <= model_seg(m_cyc, m_frame);
            exp_dp  <= model_dp(m_cyc);
            exp_lap <= m_hold ^ (LAP & lap);
            m_hold  <= m_hold ^ (LAP & lap);
            if ((m_cyc % FRAME) == FRAME - 1 && !(m_hold ^ (LAP & lap)))
                m_frame <= {dg[7], dg[6], dg[5], dg[4], dg[3], dg[2], dg[1], dg[0]};
            m_cyc <= m_cyc + 1;
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("an_n", 32'(an_n), 32'(exp_an));
            chk("seg_n", 32'(seg_n), 32'(exp_seg));
            chk("dp_n", 32'(dp_n), 32'(exp_dp));
            chk("lap_active", 32'(lap_active), 32'(exp_lap));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Advance until the outputs show slot s on its first enabled cycle.
    task automatic goto_view(input int s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if ((m_cyc % FRAME) == s * D + 2) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_view: slot %0d not reached within bound", s);
        end
    endtask

    // Advance until the next sampled cycle is a frame end.
    task automatic goto_boundary();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if ((m_cyc % FRAME) == FRAME - 1) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_boundary: not reached within bound");
        end
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        tick();
        lap = 1'b0;
    endtask

    task automatic rand_digits();
        for (int k = 0; k < 8; k++) dg[k] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        lap   = 1'b0;
        for (int k = 0; k < 8; k++) dg[k] = 4'd0;

        // Reset and the two cycles after release.
        repeat (3) tick();
        chk("rst_an", 32'(an_n), 32'hFF);
        chk("rst_lap", 32'(lap_active), 32'h0);
        reset = 1'b0;
        tick();
        chk("post1_an", 32'(an_n), 32'hFF);
        chk("post1_seg", 32'(seg_n), 32'h7F);
        chk("post1_dp", 32'(dp_n), 32'h1);
        tick();
        chk("post2_an", 32'(an_n), 32'hFE);
        chk("post2_seg", 32'(seg_n), 32'h40);

        // d8..d1 = 1..8
        for (int k = 0; k < 8; k++) dg[k] = 4'(8 - k);
        goto_view(0);
        chk("d1_eight", 32'(seg_n), 32'h00);
        dg[0] = 4'd3;
        tick();
        chk("d1_still_eight", 32'(seg_n), 32'h00);
        goto_view(2);
        chk("dp_slot2", 32'(dp_n), 32'h0);
        chk("an_slot2", 32'(an_n), 32'hFB);
        goto_view(3);
        chk("dp_slot3", 32'(dp_n), 32'h1);
        goto_view(7);
        chk("d8_one", 32'(seg_n), 32'h79);
        goto_view(0);
        chk("d1_three", 32'(seg_n), 32'h30);

        // Leading-zero blank and dash.
        dg[7] = 4'd0;
        goto_view(0);
        goto_view(7);
        chk("lead_blank_seg", 32'(seg_n), 32'h7F);
        chk("lead_blank_dp", 32'(dp_n), 32'h1);
        chk("lead_blank_an", 32'(an_n), 32'h7F);
        dg[7] = 4'hA;
        goto_view(0);
        goto_view(7);
        chk("dash", 32'(seg_n), 32'h3F);

        // Lap hold across three frames of changing inputs, then release.
        goto_view(3);
        pulse_lap();
        chk("lap_set", 32'(lap_active), 32'(LAP));
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i % 5 == 0) rand_digits();
            tick();
        end
        goto_view(4);
        pulse_lap();
        chk("lap_clear", 32'(lap_active), 32'h0);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Pulse that sets hold on a boundary blocks that load.
        rand_digits();
        goto_boundary();
        pulse_lap();
        rand_digits();
        for (int i = 0; i < 2 * FRAME; i++) tick();
        // Pulse that clears hold on a boundary lets that load through.
        goto_boundary();
        pulse_lap();
        for (int i = 0; i < FRAME + 4; i++) tick();

        // Randomized run.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) rand_digits();
            lap = ($urandom_range(0, 49) == 0);
            tick();
        end
        lap = 1'b0;

        // Reset while held.
        if (LAP && !m_hold) pulse_lap();
        tick();
        for (int k = 0; k < 8; k++) dg[k] = 4'd9;
        reset = 1'b1;
        tick();
        chk("rst_held_lap", 32'(lap_active), 32'h0);
        chk("rst_held_an", 32'(an_n), 32'hFF);
        reset = 1'b0;
        goto_view(0);
        chk("rst_frame_d1", 32'(seg_n), 32'h40);
        goto_view(7);
        chk("rst_frame_d8", 32'(seg_n), 32'h7F);
        for (int i = 0; i < FRAME; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_display
`default_nettype wire
